// File: rtl/uart_rx_axis.sv
// UART receiver (8x prescaled bit timing, mid-bit sampling) feeding a single-entry AXI-Stream holding register.
// Framing and overrun errors pulse for one cycle; a break after a bad stop bit holds the receiver busy until the line recovers.
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error
);
  localparam int TW = 19;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                r_state, w_state_next;
  logic                  r_sync0, r_sync1;
  logic [1:0]            r_settle;
  logic                  r_armed;
  logic                  r_brk, w_brk_next;
  logic [15:0]           r_ps, w_ps_next;
  logic [TW-1:0]         r_tick, w_tick_next;
  logic [BW-1:0]         r_bit, w_bit_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                  w_good, w_bad;
  logic                  w_rxd_s;
  logic [15:0]           w_ps_eff;
  logic [TW-1:0]         w_half, w_full;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid, r_ovr, r_fe;

  assign w_rxd_s  = r_sync1;
  assign w_ps_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_half   = {1'b0, w_ps_eff, 2'b00} - TW'(1);
  assign w_full   = {r_ps, 3'b000} - TW'(1);

  // r_armed blocks start detection until the real line has been seen high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0  <= 1'b1;
      r_sync1  <= 1'b1;
      r_settle <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_sync0  <= rxd;
      r_sync1  <= r_sync0;
      r_settle <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_rxd_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_brk   <= 1'b0;
      r_ps    <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_brk   <= w_brk_next;
      r_ps    <= w_ps_next;
      r_tick  <= w_tick_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_brk_next   = r_brk;
    w_ps_next    = r_ps;
    w_tick_next  = r_tick;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed && !w_rxd_s) begin
          w_state_next = START;
          w_ps_next    = w_ps_eff;
          w_tick_next  = w_half;
          w_bit_next   = '0;
          w_brk_next   = 1'b0;
        end
      end
      START: begin
        if (r_tick != '0) begin
          w_tick_next = r_tick - TW'(1);
        end else if (w_rxd_s) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DATA;
          w_tick_next  = w_full;
        end
      end
      DATA: begin
        if (r_tick != '0) begin
          w_tick_next = r_tick - TW'(1);
        end else begin
          w_shift_next = DATA_WIDTH'({w_rxd_s, r_shift} >> 1);
          w_tick_next  = w_full;
          if (r_bit == BW'(DATA_WIDTH - 1)) begin
            w_state_next = STOP;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end
      end
      STOP: begin
        // after a bad stop bit, wait here for the line to go high
        if (r_brk) begin
          if (w_rxd_s) begin
            w_state_next = IDLE;
            w_brk_next   = 1'b0;
          end
        end else if (r_tick != '0) begin
          w_tick_next = r_tick - TW'(1);
        end else if (w_rxd_s) begin
          w_good       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_bad      = 1'b1;
          w_brk_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // a completing frame may load only if the holding register is empty or being drained this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_ovr    <= 1'b0;
      r_fe     <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      r_fe  <= w_bad;
      if (w_good && (!r_tvalid || m_axis_tready)) begin
        r_tdata  <= r_shift;
        r_tvalid <= 1'b1;
      end else if (w_good) begin
        r_ovr <= 1'b1;
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign overrun_error = r_ovr;
  assign frame_error   = r_fe;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: serial frames driven on falling clock edges, outputs observed mid-cycle.
module tb_uart_rx_axis;
  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [15:0] prescale;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy;
  logic       overrun_error;
  logic       frame_error;

  uart_rx_axis #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .prescale(prescale),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .overrun_error(overrun_error), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int t_fall = 0;

  always @(posedge clk) cyc++;

  // observer: records events mid-cycle, after inputs settle and before the next rising edge
  logic [7:0] rx_log [0:63];
  int rx_n = 0, n_vhi = 0, n_fe = 0, n_ovr = 0;
  int rise_cyc = -1, fe_cyc = -1, ovr_cyc = -1;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    #2;
    if (m_axis_tvalid && !prev_v) rise_cyc = cyc;
    prev_v = m_axis_tvalid;
    if (m_axis_tvalid) n_vhi++;
    if (m_axis_tvalid && m_axis_tready && rx_n < 64) begin
      rx_log[rx_n] = m_axis_tdata;
      rx_n++;
    end
    if (frame_error) begin n_fe++; fe_cyc = cyc; end
    if (overrun_error) begin n_ovr++; ovr_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_bit, input int p);
    logic [9:0] fr;
    int n;
    n  = (p == 0) ? 8 : 8 * p;
    fr = {stop_bit, d, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (n) @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rx, b_vhi, b_fe, b_ovr;
    rst = 1'b1; rxd = 1'b1; prescale = 16'd1; m_axis_tready = 1'b0;
    wn(3);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun_error, 0);
    check("rst_fe", frame_error, 0);
    rst = 1'b0;
    wn(5);

    // single byte, consumer ready
    m_axis_tready = 1'b1;
    b_rx = rx_n; b_vhi = n_vhi; b_fe = n_fe; b_ovr = n_ovr;
    send(8'hA5, 1'b1, 1);
    rxd = 1'b1; wn(4);
    check("a5_latency", rise_cyc - t_fall, 79);
    check("a5_one_cycle", n_vhi - b_vhi, 1);
    check("a5_count", rx_n - b_rx, 1);
    check("a5_data", rx_log[b_rx], 8'hA5);
    check("a5_no_err", (n_fe - b_fe) + (n_ovr - b_ovr), 0);
    check("a5_busy_after", busy, 0);

    // prescale 0 behaves as 1
    b_rx = rx_n;
    prescale = 16'd0;
    send(8'h5A, 1'b1, 0);
    rxd = 1'b1; wn(4);
    prescale = 16'd1;
    check("ps0_latency", rise_cyc - t_fall, 79);
    check("ps0_data", rx_log[b_rx], 8'h5A);

    // overrun: two back-to-back frames with no consumer
    m_axis_tready = 1'b0;
    b_rx = rx_n; b_fe = n_fe; b_ovr = n_ovr;
    send(8'h3C, 1'b1, 1);
    send(8'hC3, 1'b1, 1);
    rxd = 1'b1; wn(4);
    check("ovr_count", n_ovr - b_ovr, 1);
    check("ovr_timing", ovr_cyc - t_fall, 79);
    check("ovr_tvalid_held", m_axis_tvalid, 1);
    check("ovr_tdata_held", m_axis_tdata, 8'h3C);
    check("ovr_no_fe", n_fe - b_fe, 0);
    m_axis_tready = 1'b1; wn(1); m_axis_tready = 1'b0; wn(3);
    check("ovr_drain_count", rx_n - b_rx, 1);
    check("ovr_drain_data", rx_log[b_rx], 8'h3C);
    check("ovr_drained_empty", m_axis_tvalid, 0);

    // bad stop bit followed by a held-low break
    m_axis_tready = 1'b1;
    b_rx = rx_n; b_vhi = n_vhi; b_fe = n_fe; b_ovr = n_ovr;
    send(8'h55, 1'b0, 1);
    wn(100);
    check("fe_count", n_fe - b_fe, 1);
    check("fe_timing", fe_cyc - t_fall, 79);
    check("fe_no_valid", n_vhi - b_vhi, 0);
    check("fe_break_busy", busy, 1);
    check("fe_no_ovr", n_ovr - b_ovr, 0);
    rxd = 1'b1; wn(5);
    check("fe_break_end", busy, 0);
    fork
      send(8'h12, 1'b1, 1);
      begin wn(20); prescale = 16'd7; end
    join
    prescale = 16'd1;
    rxd = 1'b1; wn(4);
    check("fe_next_count", rx_n - b_rx, 1);
    check("fe_next_data", rx_log[b_rx], 8'h12);
    check("fe_next_no_fe", n_fe - b_fe, 1);

    // short start glitch with prescale 4
    prescale = 16'd4;
    b_vhi = n_vhi; b_fe = n_fe; b_ovr = n_ovr;
    rxd = 1'b0; wn(2); rxd = 1'b1;
    wn(8);
    check("gl_busy_during", busy, 1);
    wn(10);
    check("gl_busy_after", busy, 0);
    wn(40);
    check("gl_no_output", n_vhi - b_vhi, 0);
    check("gl_no_err", (n_fe - b_fe) + (n_ovr - b_ovr), 0);
    prescale = 16'd1;

    // reset in the middle of a frame
    b_rx = rx_n; b_vhi = n_vhi; b_fe = n_fe;
    fork
      send(8'hFF, 1'b1, 1);
      begin
        wn(35);
        check("mr_busy_before", busy, 1);
        rst = 1'b1; #1;
        check("mr_busy", busy, 0);
        check("mr_tvalid", m_axis_tvalid, 0);
        check("mr_tdata", m_axis_tdata, 0);
        check("mr_errs", {frame_error, overrun_error}, 0);
        wn(3);
        rst = 1'b0;
      end
    join
    rxd = 1'b1; wn(10);
    check("mr_no_output", n_vhi - b_vhi, 0);
    check("mr_no_fe", n_fe - b_fe, 0);
    send(8'h81, 1'b1, 1);
    rxd = 1'b1; wn(4);
    check("mr_next_latency", rise_cyc - t_fall, 79);
    check("mr_next_data", rx_log[b_rx], 8'h81);

    // line already low when reset releases: no start until seen high
    b_fe = n_fe; b_rx = rx_n;
    rxd = 1'b0; wn(2);
    rst = 1'b1; wn(2); rst = 1'b0;
    wn(10);
    check("lowrst_busy", busy, 0);
    wn(110);
    check("lowrst_busy_late", busy, 0);
    check("lowrst_no_fe", n_fe - b_fe, 0);
    rxd = 1'b1; wn(5);
    send(8'h7E, 1'b1, 1);
    rxd = 1'b1; wn(4);
    check("lowrst_next_data", rx_log[b_rx], 8'h7E);

    // consumer ready exactly when the second byte completes
    m_axis_tready = 1'b0;
    b_rx = rx_n; b_ovr = n_ovr;
    fork
      begin send(8'h01, 1'b1, 1); send(8'h02, 1'b1, 1); end
      begin wn(158); m_axis_tready = 1'b1; wn(1); m_axis_tready = 1'b0; end
    join
    rxd = 1'b1; wn(4);
    check("hs_no_ovr", n_ovr - b_ovr, 0);
    check("hs_first_count", rx_n - b_rx, 1);
    check("hs_first_data", rx_log[b_rx], 8'h01);
    check("hs_tvalid_kept", m_axis_tvalid, 1);
    check("hs_tdata_new", m_axis_tdata, 8'h02);
    m_axis_tready = 1'b1; wn(1); m_axis_tready = 1'b0; wn(3);
    check("hs_second_data", rx_log[b_rx + 1], 8'h02);
    check("hs_empty", m_axis_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/uart_rx_axis.md
UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per UART frame.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rxd  input  1  serial line; idles high; LSB first; 1 start bit, DATA_WIDTH data bits, 1 stop bit, no parity.
REQ-005 prescale  input  16  clocks per 1/8 bit; bit period P8 = 8*prescale clocks.
REQ-006 m_axis_tdata  output  DATA_WIDTH  received byte.
REQ-007 m_axis_tvalid  output  1  received byte available.
REQ-008 m_axis_tready  input  1  consumer accepts byte.
REQ-009 busy  output  1  high while a frame is being received.
REQ-010 overrun_error  output  1  one-cycle pulse when a good frame is lost.
REQ-011 frame_error  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-013 prescale SHALL be sampled at start-bit detection and held for the frame; prescale 0 SHALL be treated as 1.
REQ-014 States SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE -> START on the first cycle T0 with rxd_s == 0; busy SHALL be high from T0+1 until the return to IDLE.
REQ-016 START: at T0+4*prescale rxd_s SHALL be sampled. If 0 -> DATA. If 1 -> glitch: return to IDLE with no output and no error.
REQ-017 DATA: bit i (i = 0..DATA_WIDTH-1) SHALL be sampled at T0+4*prescale+P8*(i+1) and shifted in LSB first.
REQ-018 STOP: stop bit SHALL be sampled at T0+4*prescale+P8*(DATA_WIDTH+1).
REQ-019 Good frame (stop = 1) with m_axis_tvalid low: tdata loads and tvalid asserts on the next edge.
- For prescale = 1, DATA_WIDTH = 8: tvalid high from T0+77.
REQ-020 Bad frame (stop = 0): frame_error SHALL pulse for exactly one cycle; data is discarded; tvalid and tdata are unchanged.
REQ-021 After a bad stop bit, the FSM SHALL stay out of IDLE until rxd_s == 1, so that a held-low line (break) is not taken as a new start.
REQ-022 Handshake: tvalid SHALL remain high and tdata stable until a cycle with m_axis_tready == 1; tvalid SHALL clear on that edge.
REQ-023 Overrun: a good frame completing while tvalid is high and tready is low SHALL pulse overrun_error for one cycle; the new byte is dropped and the held byte is kept.
REQ-024 If tready is high in the same cycle a new good frame completes, the old byte is consumed, the new byte loads with tvalid staying high, and no overrun is flagged.
REQ-025 After the stop-bit sample the FSM SHALL return to IDLE, so that back-to-back frames with zero idle time are received.
REQ-026 Counters: a prescale-based tick counter and a bit counter of width clog2(DATA_WIDTH+1); neither SHALL wrap mid-frame.
REQ-027 frame_error and overrun_error SHALL never assert together for the same frame.

Reset
REQ-028 While rst is high:
- state = IDLE
- both synchronizer flops = 1
- m_axis_tdata = 0, m_axis_tvalid = 0
- busy = 0, overrun_error = 0, frame_error = 0
- all counters = 0
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output and no error pulse.
REQ-030 After rst deasserts, a line already low SHALL be treated as a start bit only once it has been seen high first (same rule as REQ-021).

Verification
REQ-031 prescale = 1, send 0xA5 with tready = 1 -> tvalid one cycle at T0+77, tdata = 0xA5, no errors, busy low after.
REQ-032 prescale = 1, tready = 0, send 0x3C then 0xC3 back-to-back -> tdata holds 0x3C, overrun_error pulses once at the end of the 2nd frame; raising tready then drains 0x3C only.
REQ-033 prescale = 1, send 0x55 with stop bit forced 0 -> frame_error one-cycle pulse, tvalid stays 0; the next good frame 0x12 is received correctly.
REQ-034 prescale = 4, 2-clock low glitch on rxd -> no busy after the START check, no output, no errors.
REQ-035 prescale = 1, assert rst during bit 3 of 0xFF -> all outputs 0 immediately; a subsequent 0x81 is received correctly.
REQ-036 prescale = 1, tready pulsed high in the exact cycle the 2nd byte completes (0x01, 0x02) -> both bytes delivered in order, no overrun.
